// File: rtl/prog_counter_pkg.sv
// Shared definitions for the programmable counter: counting modes and the
// per-edge action priority (clear > load > tick).
package prog_counter_pkg;

  // Run-time counting mode, encoded as driven on the mode pin.
  typedef enum logic [1:0] {
    MODE_FREE     = 2'd0,
    MODE_MOD      = 2'd1,
    MODE_ONESHOT  = 2'd2,
    MODE_PINGPONG = 2'd3
  } mode_e;

  // Action taken on an edge, listed from highest to lowest priority.
  typedef enum logic [1:0] {
    PRIO_CLEAR = 2'd0,
    PRIO_LOAD  = 2'd1,
    PRIO_TICK  = 2'd2,
    PRIO_IDLE  = 2'd3
  } prio_e;

endpackage

// File: rtl/prog_counter_prescaler.sv
// Tick divider: one tick per (prescale+1) enabled cycles; restart zeroes it.
// Only built when PROG_COUNTER_PRESCALE_EN is defined.
// Ports: clk, rst_n (async, active-low), en, restart, prescale -> tick.
`ifdef PROG_COUNTER_PRESCALE_EN
module prog_counter_prescaler #(
  parameter int unsigned PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  restart,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] pre_q, pre_d;

  assign tick = en && (pre_q == prescale);

  // Next prescaler phase; restart takes effect even when disabled.
  always_comb begin
    pre_d = pre_q;
    if (restart) begin
      pre_d = '0;
    end else if (en) begin
      pre_d = (pre_q == prescale) ? '0 : pre_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pre_q <= '0;
    else        pre_q <= pre_d;
  end

endmodule
`endif

// File: rtl/prog_counter_gen.sv
// Parametrised programmable counter with FREE / MOD / ONESHOT / PINGPONG modes.
// Optional prescaler enabled by macro PROG_COUNTER_PRESCALE_EN; otherwise
// every enabled cycle is a tick and the prescale port is unused.
// Ports: clk, rst_n (async, active-low), en, clear, load, load_val, up, mode,
//        limit, prescale -> count, tc_pulse, loaded_pulse, done, dir.
module prog_counter_gen
  import prog_counter_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clear,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic                  up,
  input  logic [1:0]            mode,
  input  logic [WIDTH-1:0]      limit,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  tc_pulse,
  output logic                  loaded_pulse,
  output logic                  done,
  output logic                  dir
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ld_q, ld_d;
  logic             done_q, done_d;
  logic             dir_q, dir_d;
  logic             tick;
  logic             wrap;
  mode_e            mode_s;
  prio_e            act;

  assign mode_s = mode_e'(mode);

`ifdef PROG_COUNTER_PRESCALE_EN
  prog_counter_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .restart  (clear | load),
    .prescale (prescale),
    .tick     (tick)
  );
`else
  logic _unused;
  assign _unused = ^prescale;
  assign tick    = en;
`endif

  // Resolve the single action for this edge.
  always_comb begin
    if (clear)     act = PRIO_CLEAR;
    else if (load) act = PRIO_LOAD;
    else if (tick) act = PRIO_TICK;
    else           act = PRIO_IDLE;
  end

  // Next-state for count, flags and the ping-pong direction.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    ld_d    = 1'b0;
    done_d  = done_q;
    dir_d   = dir_q;
    wrap    = up ? (count_q >= limit) : (count_q == '0);

    // done only survives in ONESHOT; direction only latches in PINGPONG.
    if (mode_s != MODE_ONESHOT)  done_d = 1'b0;
    if (mode_s != MODE_PINGPONG) dir_d  = up;

    unique case (act)
      PRIO_CLEAR: begin
        count_d = '0;
        done_d  = 1'b0;
        dir_d   = up;
      end
      PRIO_LOAD: begin
        count_d = load_val;
        done_d  = 1'b0;
        dir_d   = up;
        ld_d    = 1'b1;
      end
      PRIO_TICK: begin
        unique case (mode_s)
          MODE_FREE: begin
            count_d = up ? count_q + CNT_ONE : count_q - CNT_ONE;
            tc_d    = up ? (count_q == CNT_MAX) : (count_q == '0);
          end
          MODE_MOD: begin
            if (wrap) begin
              count_d = up ? '0 : limit;
              tc_d    = 1'b1;
            end else begin
              count_d = up ? count_q + CNT_ONE : count_q - CNT_ONE;
            end
          end
          MODE_ONESHOT: begin
            // Where MOD would wrap, hold and finish; ignore ticks once done.
            if (!done_q) begin
              if (wrap) begin
                done_d = 1'b1;
                tc_d   = 1'b1;
              end else begin
                count_d = up ? count_q + CNT_ONE : count_q - CNT_ONE;
              end
            end
          end
          MODE_PINGPONG: begin
            // A zero-length range pins the count at 0 with a tc every tick.
            if ((limit == '0) && (count_q == '0)) begin
              tc_d = 1'b1;
            end else if (dir_q) begin
              if (count_q >= limit) begin
                count_d = count_q - CNT_ONE;
                dir_d   = 1'b0;
                tc_d    = 1'b1;
              end else begin
                count_d = count_q + CNT_ONE;
              end
            end else begin
              if (count_q == '0) begin
                count_d = CNT_ONE;
                dir_d   = 1'b1;
                tc_d    = 1'b1;
              end else begin
                count_d = count_q - CNT_ONE;
              end
            end
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ld_q    <= 1'b0;
      done_q  <= 1'b0;
      dir_q   <= 1'b1;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ld_q    <= ld_d;
      done_q  <= done_d;
      dir_q   <= dir_d;
    end
  end

  assign count        = count_q;
  assign tc_pulse     = tc_q;
  assign loaded_pulse = ld_q;
  assign done         = done_q;
  assign dir          = (mode_s == MODE_PINGPONG) ? dir_q : up;

endmodule
